bcd_scan_display: RTL and testbench

Parametrised debug display engine that replaces the combinational per-value binary-to-BCD plus seven-segment chain on the board top level. It time-shares one sequential double-dabble converter round-robin across CHANNELS binary inputs, such as PC and SP. Each conversion is latched into per-digit seven-segment registers. It adds leading-zero blanking, overflow indication, a freeze control and a frame-complete strobe.

---
 rtl/bcd_scan_display.sv | 165 ++++++++++++++++
 tb/tb_bcd_scan_display.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - round-robin double-dabble BCD to seven-segment display engine
module bcd_scan_display #(
    parameter int WIDTH       = 6,
    parameter int DIGITS      = 2,
    parameter int CHANNELS    = 2,
    parameter bit BLANK_ZEROS = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           freeze,
    input  logic [CHANNELS*WIDTH-1:0]      in,
    output logic [7*DIGITS*CHANNELS-1:0]   hex,
    output logic [CHANNELS-1:0]            ovf,
    output logic                           frame
);

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int d);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < d) p = p * 64'd10;
        end
        if (d > 19) p = '1;
        return p;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Accumulator is sized for the full input range even if fewer digits are shown.
    localparam int NAT_DIGITS = dec_digits(WIDTH);
    localparam int ACC_DIGITS = (NAT_DIGITS > DIGITS) ? NAT_DIGITS : DIGITS;
    localparam int BCD_W      = 4 * ACC_DIGITS;
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W      = $clog2(WIDTH + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} state_t;

    state_t              state;
    state_t              state_next;
    logic [CH_W-1:0]     ch;
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [WIDTH-1:0]    bin;
    logic [WIDTH-1:0]    in_sel;
    logic                ovf_pending;
    logic [7*DIGITS-1:0] commit_word;

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (!freeze) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch == CH_W'(c)) in_sel = in[WIDTH*c +: WIDTH];
        end
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + ((bcd[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    // Walk from the most significant shown digit down so "lead" means all digits above are zero.
    always_comb begin
        logic       lead;
        logic [3:0] digit;
        commit_word = '1;
        lead        = 1'b1;
        digit       = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            digit = bcd[4*d +: 4];
            if (digit != 4'd0) lead = 1'b0;
            if (ovf_pending)
                commit_word[7*d +: 7] = SEG_DASH;
            else if (BLANK_ZEROS && lead && (d > 0))
                commit_word[7*d +: 7] = SEG_BLANK;
            else
                commit_word[7*d +: 7] = seg_code(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            ch          <= '0;
            cnt         <= '0;
            bcd         <= '0;
            bin         <= '0;
            ovf_pending <= 1'b0;
            hex         <= '1;
            ovf         <= '0;
            frame       <= 1'b0;
        end else begin
            state <= state_next;
            frame <= 1'b0;
            case (state)
                LOAD: begin
                    if (!freeze) begin
                        bin         <= in_sel;
                        bcd         <= '0;
                        ovf_pending <= (64'(in_sel) >= LIMIT);
                        cnt         <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                end
                COMMIT: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (ch == CH_W'(c)) begin
                            hex[7*DIGITS*c +: 7*DIGITS] <= commit_word;
                            ovf[c]                      <= ovf_pending;
                        end
                    end
                    frame <= (ch == CH_W'(CHANNELS - 1));
                    ch    <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display
module tb_bcd_scan_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, frz_a;
    logic [11:0] in_a;
    logic [27:0] hex_a;
    logic [1:0]  ovf_a;
    logic        frame_a;

    logic        rst_b;
    logic [11:0] in_b;
    logic [27:0] hex_b;
    logic [1:0]  ovf_b;
    logic        frame_b;

    logic        rst_c;
    logic [7:0]  in_c;
    logic [13:0] hex_c;
    logic        ovf_c;
    logic        frame_c;

    bcd_scan_display dut_a (
        .clk(clk), .rst_n(rst_a), .freeze(frz_a), .in(in_a),
        .hex(hex_a), .ovf(ovf_a), .frame(frame_a)
    );

    bcd_scan_display #(.BLANK_ZEROS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .freeze(1'b0), .in(in_b),
        .hex(hex_b), .ovf(ovf_b), .frame(frame_b)
    );

    bcd_scan_display #(.WIDTH(8), .DIGITS(2), .CHANNELS(1)) dut_c (
        .clk(clk), .rst_n(rst_c), .freeze(1'b0), .in(in_c),
        .hex(hex_c), .ovf(ovf_c), .frame(frame_c)
    );

    typedef struct {
        int          ch;
        logic [13:0] seg;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] model(input int v, input bit blank);
        logic [6:0] tens;
        if (v >= 100) return {7'b0111111, 7'b0111111};
        tens = (blank && v < 10) ? 7'b1111111 : seg_of(v / 10);
        return {tens, seg_of(v % 10)};
    endfunction

    function automatic exp_t mk(input int ch, input int v, input bit blank);
        exp_t e;
        e.ch  = ch;
        e.seg = model(v, blank);
        e.ovf = (v >= 100);
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a;
        rst_a = 1'b0;
        frz_a = 1'b0;
        tick;
        tick;
        rst_a = 1'b1;
    endtask

    // Next edge must be the LOAD of channel ch; returns just after its commit edge.
    task automatic run_channel_a(input int ch, input int v);
        exp_t e;
        bit   quiet;
        in_a[6*ch +: 6] = v[5:0];
        sb.push_back(mk(ch, v, 1'b0));
        quiet = 1'b1;
        repeat (7) begin
            tick;
            if (frame_a !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL early_frame ch%0d: frame seen before commit, want none", ch);
        end
        tick;
        e = sb.pop_front();
        total++;
        if (hex_a[14*e.ch +: 14] !== e.seg) begin
            bad++;
            $display("FAIL hex ch%0d v=%0d: got %b want %b", e.ch, v, hex_a[14*e.ch +: 14], e.seg);
        end
        total++;
        if (ovf_a[e.ch] !== e.ovf) begin
            bad++;
            $display("FAIL ovf ch%0d: got %b want %b", e.ch, ovf_a[e.ch], e.ovf);
        end
        total++;
        if (frame_a !== (e.ch == 1)) begin
            bad++;
            $display("FAIL frame ch%0d: got %b want %b", e.ch, frame_a, (e.ch == 1));
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b0;
        frz_a = 1'b0;
        in_a  = '0;
        tick;
        total++;
        if (hex_a !== '1) begin
            bad++;
            $display("FAIL reset_hex: got %h want %h", hex_a, 28'hfffffff);
        end
        total++;
        if (ovf_a !== 2'b00) begin
            bad++;
            $display("FAIL reset_ovf: got %b want 00", ovf_a);
        end
        total++;
        if (frame_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_frame: got %b want 0", frame_a);
        end
    endtask

    task automatic test_defaults;
        reset_a;
        run_channel_a(0, 37);
        run_channel_a(1, 5);
        total++;
        if (hex_a !== {7'b1000000, 7'b0010010, 7'b0110000, 7'b1111000}) begin
            bad++;
            $display("FAIL defaults_word: got %b want %b", hex_a,
                     {7'b1000000, 7'b0010010, 7'b0110000, 7'b1111000});
        end
        tick;
        total++;
        if (frame_a !== 1'b0) begin
            bad++;
            $display("FAIL frame_width: got %b want 0", frame_a);
        end
    endtask

    task automatic test_max;
        // previous tick already consumed the LOAD edge of ch0; realign with a fresh frame
        reset_a;
        run_channel_a(0, 63);
        total++;
        if (hex_a[13:0] !== {7'b0000010, 7'b0110000}) begin
            bad++;
            $display("FAIL max63: got %b want %b", hex_a[13:0], {7'b0000010, 7'b0110000});
        end
        run_channel_a(1, 0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            run_channel_a(i % 2, int'($urandom_range(0, 63)));
        end
    endtask

    task automatic test_snapshot;
        exp_t e;
        in_a[5:0] = 6'd37;
        sb.push_back(mk(0, 37, 1'b0));
        tick;
        in_a[5:0] = 6'd50;
        repeat (7) tick;
        e = sb.pop_front();
        total++;
        if (hex_a[13:0] !== e.seg) begin
            bad++;
            $display("FAIL snapshot: got %b want %b", hex_a[13:0], e.seg);
        end
        run_channel_a(1, 9);
    endtask

    task automatic test_freeze;
        exp_t        e;
        logic [27:0] hold_hex;
        logic [1:0]  hold_ovf;
        bit          same_hex, same_ovf, no_frame;
        in_a[5:0] = 6'd42;
        sb.push_back(mk(0, 42, 1'b0));
        tick;
        tick;
        tick;
        frz_a = 1'b1;
        repeat (5) tick;
        e = sb.pop_front();
        total++;
        if (hex_a[13:0] !== e.seg) begin
            bad++;
            $display("FAIL freeze_commit: got %b want %b", hex_a[13:0], e.seg);
        end
        hold_hex  = hex_a;
        hold_ovf  = ovf_a;
        in_a[11:6] = 6'd17;
        same_hex = 1'b1;
        same_ovf = 1'b1;
        no_frame = 1'b1;
        repeat (50) begin
            tick;
            if (hex_a !== hold_hex) same_hex = 1'b0;
            if (ovf_a !== hold_ovf) same_ovf = 1'b0;
            if (frame_a !== 1'b0) no_frame = 1'b0;
        end
        total++;
        if (!same_hex) begin bad++; $display("FAIL freeze_hex: changed, want constant"); end
        total++;
        if (!same_ovf) begin bad++; $display("FAIL freeze_ovf: changed, want constant"); end
        total++;
        if (!no_frame) begin bad++; $display("FAIL freeze_frame: pulsed, want none"); end
        frz_a = 1'b0;
        sb.push_back(mk(1, 17, 1'b0));
        repeat (7) tick;
        total++;
        if (hex_a[27:14] !== model(9, 1'b0)) begin
            bad++;
            $display("FAIL freeze_early: got %b want %b", hex_a[27:14], model(9, 1'b0));
        end
        tick;
        e = sb.pop_front();
        total++;
        if (hex_a[27:14] !== e.seg || frame_a !== 1'b1) begin
            bad++;
            $display("FAIL freeze_resume: got %b/%b want %b/1", hex_a[27:14], frame_a, e.seg);
        end
    endtask

    task automatic test_reset_mid_shift;
        exp_t e;
        bit   clean;
        run_channel_a(0, 12);
        in_a[11:6] = 6'd37;
        tick;
        tick;
        tick;
        rst_a = 1'b0;
        tick;
        total++;
        if (hex_a !== '1 || ovf_a !== 2'b00) begin
            bad++;
            $display("FAIL midreset: got %h/%b want fffffff/00", hex_a, ovf_a);
        end
        rst_a = 1'b1;
        in_a  = {6'd45, 6'd21};
        sb.push_back(mk(0, 21, 1'b0));
        clean = 1'b1;
        repeat (7) begin
            tick;
            if (hex_a !== '1 || frame_a !== 1'b0) clean = 1'b0;
        end
        total++;
        if (!clean) begin bad++; $display("FAIL midreset_stale: output moved before ch0 commit"); end
        tick;
        e = sb.pop_front();
        total++;
        if (hex_a !== {14'h3fff, e.seg} || frame_a !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ch0first: got %h/%b want %h/0", hex_a, frame_a, {14'h3fff, e.seg});
        end
    endtask

    task automatic test_blank;
        exp_t e;
        int   vals[4] = '{0, 5, 40, 7};
        rst_b = 1'b0;
        tick;
        tick;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_b[6*(i%2) +: 6] = vals[i][5:0];
            sb.push_back(mk(i % 2, vals[i], 1'b1));
            repeat (8) tick;
            e = sb.pop_front();
            total++;
            if (hex_b[14*e.ch +: 14] !== e.seg || frame_b !== (e.ch == 1)) begin
                bad++;
                $display("FAIL blank v=%0d: got %b/%b want %b/%b", vals[i],
                         hex_b[14*e.ch +: 14], frame_b, e.seg, (e.ch == 1));
            end
        end
    endtask

    task automatic test_wide;
        exp_t e;
        int   vals[3] = '{200, 99, 100};
        rst_c = 1'b0;
        tick;
        tick;
        rst_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_c = vals[i][7:0];
            sb.push_back(mk(0, vals[i], 1'b0));
            repeat (10) tick;
            e = sb.pop_front();
            total++;
            if (hex_c !== e.seg || ovf_c !== e.ovf || frame_c !== 1'b1) begin
                bad++;
                $display("FAIL wide v=%0d: got %b/%b/%b want %b/%b/1", vals[i],
                         hex_c, ovf_c, frame_c, e.seg, e.ovf);
            end
        end
    endtask

    initial begin
        rst_a = 1'b0;
        frz_a = 1'b0;
        in_a  = '0;
        rst_b = 1'b0;
        in_b  = '0;
        rst_c = 1'b0;
        in_c  = '0;
        test_reset;
        test_defaults;
        test_max;
        test_back_to_back;
        test_snapshot;
        test_freeze;
        test_reset_mid_shift;
        test_blank;
        test_wide;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
